// File: rtl/seg_mon_pkg.sv
// Shared types for the seven-segment bus monitor: view encodings, hold states, display width.
package seg_mon_pkg;

  localparam int DISP_W = 16;

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_WRITE = 2'd1,
    MODE_READ  = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hold_t;

  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low push-button conditioner: two-flop synchroniser, stability timer, press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Down-counter reloads on any agreeing sample; terminal count accepts the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= RELOAD;
      press <= 1'b0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level <= sync2;
        cnt   <= RELOAD;
        press <= ~sync2;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/seg_bus_monitor.sv
// Snoops the CPU bus and builds the 16-bit word shown on the four-digit hex display.
// state   | meaning
// ADDR    | show last bus address
// WRITE   | show {last write addr[7:0], write data}
// READ    | show {last read addr[7:0], read data}
// COUNT   | show write-event counter
// RUN     | display follows selected view
// HOLD    | display frozen, capture continues
module seg_bus_monitor
  import seg_mon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic              btn_mode_n,
  input  logic              btn_hold_n,
  output logic [DISP_W-1:0] disp_data,
  output logic [1:0]        mode,
  output logic              hold
);

  logic [15:0]      addr_q;
  logic [7:0]       wr_addr_lo;
  logic [7:0]       wr_data;
  logic [7:0]       rd_addr_lo;
  logic [7:0]       rd_data;
  logic [CNT_W-1:0] wcnt;
  logic             mode_press;
  logic             hold_press;
  mode_t            mode_q;
  hold_t            hold_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk   (clk),
    .rst   (rst),
    .raw_n (btn_mode_n),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold_btn (
    .clk   (clk),
    .rst   (rst),
    .raw_n (btn_hold_n),
    .press (hold_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wr_addr_lo <= '0;
      wr_data    <= '0;
      rd_addr_lo <= '0;
      rd_data    <= '0;
      wcnt       <= '0;
    end else if (cpu_en) begin
      addr_q <= cpu_addr;
      if (cpu_we) begin
        wr_addr_lo <= cpu_addr[7:0];
        wr_data    <= cpu_dout;
        wcnt       <= wcnt + CNT_W'(1);
      end else begin
        rd_addr_lo <= cpu_addr[7:0];
        rd_data    <= cpu_din;
      end
    end
  end

  // The display register samples with the pre-edge state, so a view change shows one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_ADDR;
      hold_q    <= ST_RUN;
      disp_data <= '0;
    end else begin
      if (hold_q == ST_RUN) begin
        case (mode_q)
          MODE_ADDR:  disp_data <= addr_q;
          MODE_WRITE: disp_data <= {wr_addr_lo, wr_data};
          MODE_READ:  disp_data <= {rd_addr_lo, rd_data};
          MODE_COUNT: disp_data <= wcnt[DISP_W-1:0];
        endcase
      end
      if (mode_press) mode_q <= next_mode(mode_q);
      if (hold_press) hold_q <= (hold_q == ST_RUN) ? ST_HOLD : ST_RUN;
    end
  end

  assign mode = mode_q;
  assign hold = (hold_q == ST_HOLD);

endmodule

// File: tb/tb_seg_bus_monitor.sv
// Randomised bench for seg_bus_monitor against a transaction-level model of the monitor.
module tb_seg_bus_monitor;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_en;
  logic        cpu_we;
  logic        btn_mode_n;
  logic        btn_hold_n;
  logic [15:0] disp_data;
  logic [1:0]  mode;
  logic        hold;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what the monitor has captured, which view is selected, whether frozen.
  logic [15:0] m_addr;
  logic [7:0]  m_wa, m_wd, m_ra, m_rd;
  logic [15:0] m_wcnt;
  int          m_mode;
  bit          m_hold;
  logic [15:0] m_frozen;

  seg_bus_monitor #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_din    (cpu_din),
    .cpu_en     (cpu_en),
    .cpu_we     (cpu_we),
    .btn_mode_n (btn_mode_n),
    .btn_hold_n (btn_hold_n),
    .disp_data  (disp_data),
    .mode       (mode),
    .hold       (hold)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] view(input int md);
    case (md)
      0:       return m_addr;
      1:       return {m_wa, m_wd};
      2:       return {m_ra, m_rd};
      default: return m_wcnt;
    endcase
  endfunction

  function automatic logic [15:0] exp_disp();
    return m_hold ? m_frozen : view(m_mode);
  endfunction

  task automatic model_reset();
    m_addr = '0; m_wa = '0; m_wd = '0; m_ra = '0; m_rd = '0;
    m_wcnt = '0; m_mode = 0; m_hold = 0; m_frozen = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic we, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] r);
    cpu_en = en; cpu_we = we; cpu_addr = a; cpu_dout = d; cpu_din = r;
  endtask

  task automatic apply(input logic en, input logic we, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] r);
    if (en) begin
      m_addr = a;
      if (we) begin
        m_wa = a[7:0]; m_wd = d; m_wcnt = m_wcnt + 16'd1;
      end else begin
        m_ra = a[7:0]; m_rd = r;
      end
    end
  endtask

  task automatic bus(input logic we, input logic [15:0] a, input logic [7:0] d,
                     input logic [7:0] r);
    drive(1'b1, we, a, d, r);
    tick();
    apply(1'b1, we, a, d, r);
    cpu_en = 1'b0;
  endtask

  task automatic idle(input int n);
    cpu_en = 1'b0;
    repeat (n) tick();
  endtask

  // A button level is accepted once DEB consecutive synchronised samples disagree with it.
  task automatic press(input bit pm, input bit ph, input int low);
    cpu_en = 1'b0;
    if (pm) btn_mode_n = 1'b0;
    if (ph) btn_hold_n = 1'b0;
    repeat (low) tick();
    btn_mode_n = 1'b1;
    btn_hold_n = 1'b1;
    repeat (DEB + 6) tick();
    if (low >= DEB) begin
      if (ph) begin
        if (!m_hold) m_frozen = view(m_mode);
        m_hold = !m_hold;
      end
      if (pm) m_mode = (m_mode + 1) % 4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
    btn_mode_n = 1'b1;
    btn_hold_n = 1'b1;
    model_reset();
    repeat (2) tick();
    n_checks++;
    if (disp_data !== 16'h0) begin n_fail++; $display("FAIL reset_disp: got %h expected 0000", disp_data); end
    n_checks++;
    if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    n_checks++;
    if (hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %0d expected 0", hold); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write_latency();
    bus(1'b1, 16'hC0A5, 8'h3C, 8'h00);
    n_checks++;
    if (disp_data !== 16'h0000) begin n_fail++; $display("FAIL wr_lat_early: got %h expected 0000", disp_data); end
    tick();
    n_checks++;
    if (disp_data !== 16'hC0A5) begin n_fail++; $display("FAIL wr_lat_addr: got %h expected c0a5", disp_data); end
    btn_mode_n = 1'b0;
    repeat (DEB + 2) tick();
    n_checks++;
    if (mode !== 2'd0) begin n_fail++; $display("FAIL press_lat_early: got %0d expected 0", mode); end
    tick();
    n_checks++;
    if (mode !== 2'd1) begin n_fail++; $display("FAIL press_lat_mode: got %0d expected 1", mode); end
    btn_mode_n = 1'b1;
    repeat (DEB + 6) tick();
    m_mode = 1;
    n_checks++;
    if (disp_data !== 16'hA53C) begin n_fail++; $display("FAIL write_view: got %h expected a53c", disp_data); end
  endtask

  task automatic test_read_idle();
    press(1'b1, 1'b0, DEB + 2);
    bus(1'b0, 16'hFF12, 8'h00, 8'h8D);
    idle(2);
    n_checks++;
    if (disp_data !== 16'h128D) begin n_fail++; $display("FAIL read_view: got %h expected 128d", disp_data); end
    drive(1'b0, 1'b0, 16'h1111, 8'h22, 8'h33);
    repeat (3) tick();
    n_checks++;
    if (disp_data !== 16'h128D) begin n_fail++; $display("FAIL idle_hold: got %h expected 128d", disp_data); end
    n_checks++;
    if (mode !== 2'd2) begin n_fail++; $display("FAIL read_mode: got %0d expected 2", mode); end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    logic        en, we;
    logic [15:0] a;
    logic [7:0]  d, r;
    for (int b = 0; b < 8; b++) begin
      press(1'b1, 1'b0, int'($urandom_range(1, DEB + 3)));
      n_checks++;
      if (mode !== 2'(m_mode)) begin n_fail++; $display("FAIL rnd_mode: got %0d expected %0d", mode, m_mode); end
      for (int c = 0; c < 40; c++) begin
        en = 1'($urandom); we = 1'($urandom); a = 16'($urandom);
        d = 8'($urandom); r = 8'($urandom);
        exp = exp_disp();
        drive(en, we, a, d, r);
        tick();
        apply(en, we, a, d, r);
        n_checks++;
        if (disp_data !== exp) begin n_fail++; $display("FAIL rnd_disp: got %h expected %h (mode %0d)", disp_data, exp, m_mode); end
      end
      idle(2);
    end
  endtask

  task automatic test_bounce();
    int start;
    start = m_mode;
    for (int i = 0; i < 5; i++) begin
      btn_mode_n = 1'b0; repeat (2) tick();
      btn_mode_n = 1'b1; repeat (2) tick();
    end
    idle(DEB + 6);
    n_checks++;
    if (mode !== 2'(start)) begin n_fail++; $display("FAIL bounce: got %0d expected %0d", mode, start); end
    press(1'b1, 1'b0, 6);
    n_checks++;
    if (mode !== 2'((start + 1) % 4)) begin n_fail++; $display("FAIL bounce_press: got %0d expected %0d", mode, (start + 1) % 4); end
    idle(20);
    n_checks++;
    if (mode !== 2'(m_mode)) begin n_fail++; $display("FAIL release: got %0d expected %0d", mode, m_mode); end
  endtask

  task automatic test_hold();
    while (m_mode != 0) press(1'b1, 1'b0, 6);
    bus(1'b1, 16'h1234, 8'($urandom), 8'h00);
    idle(3);
    n_checks++;
    if (disp_data !== 16'h1234) begin n_fail++; $display("FAIL hold_pre: got %h expected 1234", disp_data); end
    press(1'b0, 1'b1, 6);
    n_checks++;
    if (hold !== 1'b1) begin n_fail++; $display("FAIL hold_on: got %0d expected 1", hold); end
    bus(1'b1, 16'h5678, 8'($urandom), 8'h00);
    idle(3);
    n_checks++;
    if (disp_data !== 16'h1234) begin n_fail++; $display("FAIL hold_frozen: got %h expected 1234", disp_data); end
    press(1'b0, 1'b1, 6);
    n_checks++;
    if (hold !== 1'b0) begin n_fail++; $display("FAIL hold_off: got %0d expected 0", hold); end
    n_checks++;
    if (disp_data !== 16'h5678) begin n_fail++; $display("FAIL hold_resume: got %h expected 5678", disp_data); end
  endtask

  task automatic test_back_to_back();
    press(1'b0, 1'b1, 6);
    press(1'b1, 1'b1, 6);
    n_checks++;
    if (mode !== 2'(m_mode)) begin n_fail++; $display("FAIL both_mode: got %0d expected %0d", mode, m_mode); end
    n_checks++;
    if (hold !== 1'(m_hold)) begin n_fail++; $display("FAIL both_hold: got %0d expected %0d", hold, m_hold); end
    n_checks++;
    if (disp_data !== exp_disp()) begin n_fail++; $display("FAIL both_disp: got %h expected %h", disp_data, exp_disp()); end
    press(1'b1, 1'b1, 6);
    n_checks++;
    if (mode !== 2'(m_mode) || hold !== 1'(m_hold)) begin
      n_fail++; $display("FAIL both_run: got mode %0d hold %0d expected %0d %0d", mode, hold, m_mode, m_hold);
    end
    press(1'b0, 1'b1, 6);
    n_checks++;
    if (disp_data !== exp_disp()) begin n_fail++; $display("FAIL both_resume: got %h expected %h", disp_data, exp_disp()); end
  endtask

  task automatic test_count();
    while (m_mode != 3) press(1'b1, 1'b0, 6);
    drive(1'b1, 1'b1, 16'($urandom), 8'($urandom), 8'h00);
    while (m_wcnt != 16'hFFFE) begin
      tick();
      apply(1'b1, 1'b1, cpu_addr, cpu_dout, 8'h00);
      cpu_addr = 16'($urandom);
      cpu_dout = 8'($urandom);
    end
    idle(3);
    n_checks++;
    if (disp_data !== 16'hFFFE) begin n_fail++; $display("FAIL count_pre: got %h expected fffe", disp_data); end
    repeat (3) bus(1'b1, 16'($urandom), 8'($urandom), 8'h00);
    idle(3);
    n_checks++;
    if (disp_data !== 16'h0001) begin n_fail++; $display("FAIL count_wrap: got %h expected 0001", disp_data); end
  endtask

  task automatic test_reset_mid();
    press(1'b0, 1'b1, 6);
    btn_mode_n = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    btn_mode_n = 1'b1;
    #2;
    n_checks++;
    if (mode !== 2'd0 || hold !== 1'b0 || disp_data !== 16'h0) begin
      n_fail++; $display("FAIL async_rst: got mode %0d hold %0d disp %h expected 0 0 0000", mode, hold, disp_data);
    end
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    btn_mode_n = 1'b0;
    repeat (2) tick();
    btn_mode_n = 1'b1;
    idle(DEB + 6);
    n_checks++;
    if (mode !== 2'd0) begin n_fail++; $display("FAIL rst_short_pulse: got %0d expected 0", mode); end
    n_checks++;
    if (disp_data !== 16'h0 || hold !== 1'b0) begin
      n_fail++; $display("FAIL rst_after: got disp %h hold %0d expected 0000 0", disp_data, hold);
    end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_read_idle();
    test_random();
    test_bounce();
    test_hold();
    test_back_to_back();
    test_count();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
